// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register-file write-back queue with in-order drain and youngest-match forwarding
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     AluWrEn,
    input  logic [4:0]               AluRw,
    input  logic [31:0]              AluBus,
    input  logic                     MemWrEn,
    input  logic [4:0]               MemRw,
    input  logic [31:0]              MemBus,
    input  logic [4:0]               Ra,
    input  logic [4:0]               Rb,
    output logic                     WrEn,
    output logic [4:0]               Rw,
    output logic [31:0]              busW,
    output logic [31:0]              FwdA,
    output logic [31:0]              FwdB,
    output logic                     HitA,
    output logic                     HitB,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]    ent_rw   [DEPTH];
    logic [31:0]   ent_data [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          ovf;

    logic          pop;
    logic          live;
    logic [AW:0]   free;
    logic          alu_req;
    logic          mem_req;
    logic          alu_acc;
    logic          mem_acc;
    logic          drop;
    logic [AW:0]   n_acc;
    logic [AW-1:0] mem_slot;
    logic [AW-1:0] idx;

    // Admission: the head slot frees up this cycle if anything is pending, ALU is always the older entry
    always_comb begin
        pop      = (count != '0);
        free     = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
        alu_req  = AluWrEn && (AluRw != 5'd0);
        mem_req  = MemWrEn && (MemRw != 5'd0);
        alu_acc  = alu_req && (free != '0);
        mem_acc  = mem_req && (alu_acc ? (free >= (AW+1)'(2)) : (free != '0));
        drop     = (alu_req && !alu_acc) || (mem_req && !mem_acc);
        n_acc    = (AW+1)'(alu_acc) + (AW+1)'(mem_acc);
        mem_slot = tail + AW'(alu_acc);
    end

    // Pointer, occupancy and sticky overflow state; reset overrides any same-cycle request
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + n_acc[AW-1:0];
            count <= count - (AW+1)'(pop) + n_acc;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Entry storage is left unreset; nothing reads it unless count says it is valid
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (alu_acc) begin
                ent_rw[tail]   <= AluRw;
                ent_data[tail] <= AluBus;
            end
            if (mem_acc) begin
                ent_rw[mem_slot]   <= MemRw;
                ent_data[mem_slot] <= MemBus;
            end
        end
    end

    // Drain port presents the head entry; held quiet while reset is asserted
    always_comb begin
        live     = Rst_n && (count != '0);
        WrEn     = live;
        Rw       = live ? ent_rw[head]   : 5'd0;
        busW     = live ? ent_data[head] : 32'd0;
        Full     = Rst_n && (count >= (AW+1)'(DEPTH - 1));
        Count    = count;
        Overflow = ovf;
    end

    // Forwarding walks oldest to youngest so the last match seen is the youngest
    always_comb begin
        HitA = 1'b0;
        FwdA = 32'd0;
        HitB = 1'b0;
        FwdB = 32'd0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (Rst_n && ((AW+1)'(i) < count)) begin
                if ((Ra != 5'd0) && (ent_rw[idx] == Ra)) begin
                    HitA = 1'b1;
                    FwdA = ent_data[idx];
                end
                if ((Rb != 5'd0) && (ent_rw[idx] == Rb)) begin
                    HitB = 1'b1;
                    FwdB = ent_data[idx];
                end
            end
        end
    end

endmodule
